aes_add_round_key: RTL and testbench

// - Downstream consumer of the AES-128 key expander. Accepts a 128-bit cipher state and a round

---
 rtl/aes_add_round_key.sv | 176 +++++++++++++++++
 tb/tb_aes_add_round_key.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_add_round_key.sv
// AddRoundKey stage: fetches round key words from the key expander and XORs them into the state.
// Latency 6 cycles from accept to out_valid (FETCH_WAIT=0); out_valid holds until out_ready. Optional ADDKEY_CACHE_EN.
module aes_add_round_key #(
    parameter int NR         = 10,
    parameter int FETCH_WAIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [3:0]   round_num,
    input  logic         key_ready,
    output logic [3:0]   key_num,
    output logic [1:0]   key_idx,
    input  logic [31:0]  key_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         err
);

    localparam logic [3:0] NR_L = NR[3:0];
    localparam logic [1:0] FW   = FETCH_WAIT[1:0];

    typedef enum logic [1:0] {IDLE, WAIT_KEY, FETCH, OUT} fsm_t;

    fsm_t               fsm, fsm_nxt;
    logic [127:0]       st_lat;
    logic [2:0][31:0]   words;
    logic [1:0]         wait_cnt;
    logic               accept, bad_round, wait_done, last_word, hit_go;
    logic [127:0]       fetched_key;

    assign in_ready    = (fsm == IDLE) && !reset;
    assign accept      = in_valid && in_ready;
    assign bad_round   = round_num > NR_L;
    assign wait_done   = (wait_cnt == FW);
    assign last_word   = key_ready && wait_done && (key_idx == 2'd3);
    assign fetched_key = {words[0], words[1], words[2], key_word};

`ifdef ADDKEY_CACHE_EN
    logic         cache_vld, key_ready_d, hit_pend, cache_kill;
    logic [3:0]   cache_num;
    logic [127:0] cache_key;

    // Any falling edge of key_ready means the expander restarted, so stored keys are stale.
    assign cache_kill = key_ready_d && !key_ready;
    assign hit_go     = hit_pend && !cache_kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_vld   <= 1'b0;
            key_ready_d <= 1'b0;
            hit_pend    <= 1'b0;
            cache_num   <= 4'd0;
            cache_key   <= 128'd0;
        end else begin
            key_ready_d <= key_ready;
            if (cache_kill) begin
                cache_vld <= 1'b0;
            end else if (fsm == FETCH && last_word) begin
                cache_vld <= 1'b1;
                cache_num <= key_num;
                cache_key <= fetched_key;
            end
            if (fsm == IDLE && accept && !bad_round)
                hit_pend <= cache_vld && !cache_kill && (cache_num == round_num);
            else if (fsm == WAIT_KEY)
                hit_pend <= 1'b0;
        end
    end
`else
    logic [127:0] cache_key;
    assign hit_go    = 1'b0;
    assign cache_key = 128'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fsm <= IDLE;
        else
            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: begin
                if (accept)
                    fsm_nxt = bad_round ? OUT : WAIT_KEY;
            end
            WAIT_KEY: begin
                if (hit_go)
                    fsm_nxt = OUT;
                else if (key_ready)
                    fsm_nxt = FETCH;
            end
            FETCH: begin
                if (!key_ready)
                    fsm_nxt = WAIT_KEY;
                else if (last_word)
                    fsm_nxt = OUT;
            end
            OUT: begin
                if (out_ready)
                    fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_lat    <= 128'd0;
            words     <= '0;
            wait_cnt  <= 2'd0;
            key_num   <= 4'd0;
            key_idx   <= 2'd0;
            out_valid <= 1'b0;
            state_out <= 128'd0;
            err       <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        st_lat  <= state_in;
                        key_num <= round_num;
                        if (bad_round) begin
                            state_out <= state_in;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                WAIT_KEY: begin
                    wait_cnt <= 2'd0;
                    key_idx  <= 2'd0;
                    if (hit_go) begin
                        state_out <= st_lat ^ cache_key;
                        out_valid <= 1'b1;
                    end
                end
                FETCH: begin
                    // Expander restart: partial words are worthless, refetch from word 0.
                    if (!key_ready) begin
                        key_idx  <= 2'd0;
                        wait_cnt <= 2'd0;
                    end else if (!wait_done) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else begin
                        wait_cnt <= 2'd0;
                        key_idx  <= key_idx + 2'd1;
                        case (key_idx)
                            2'd0:    words[0] <= key_word;
                            2'd1:    words[1] <= key_word;
                            2'd2:    words[2] <= key_word;
                            default: begin
                                state_out <= st_lat ^ fetched_key;
                                out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_add_round_key.sv
// Bench for aes_add_round_key: table-driven requests against a FIPS-197 key table expander model.
module tb_aes_add_round_key;

    logic         clk, reset;
    logic         in_valid, in_ready;
    logic [127:0] state_in;
    logic [3:0]   round_num;
    logic         key_ready;
    logic [3:0]   key_num;
    logic [1:0]   key_idx;
    logic [31:0]  key_word;
    logic         out_valid, out_ready;
    logic [127:0] state_out;
    logic         err;

    aes_add_round_key dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_num (round_num),
        .key_ready (key_ready),
        .key_num   (key_num),
        .key_idx   (key_idx),
        .key_word  (key_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expander model: round keys of 2b7e151628aed2a6abf7158809cf4f3c; alt models a restarted expander.
    logic [127:0] keytab [0:10];
    logic         alt;
    logic [127:0] kfull;

    always_comb begin
        kfull = (key_num <= 4'd10) ? keytab[key_num] : 128'h0;
        if (alt)
            kfull = kfull ^ {4{32'h5a5a5a5a}};
        key_word = key_ready ? kfull[127 - 32*key_idx -: 32] : 32'hdeadbeef;
    end

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rn;
        logic [127:0] exp;
        logic         exp_err;
        int           exp_lat;
        int           exp_chg;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic accept_req(input logic [127:0] st, input logic [3:0] rn);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept timeout: in_ready stuck low");
        end
        in_valid  = 1'b1;
        state_in  = st;
        round_num = rn;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        state_in  = ~st;
        round_num = 4'hf;
    endtask

    task automatic wait_out(output int lat, output int chg);
        logic [1:0] prev;
        lat = 1;
        chg = 0;
        while (!out_valid && lat < 200) begin
            prev = key_idx;
            @(posedge clk); #1;
            lat++;
            if (key_idx != prev)
                chg++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL out timeout: out_valid never rose");
        end
    endtask

    task automatic ack(input int hold, input logic [127:0] exp_so, input logic exp_err);
        logic stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || state_out !== exp_so || err !== exp_err)
                stable = 1'b0;
        end
        if (hold > 0)
            check("hold stable", stable, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ack out_valid clear", out_valid, 1'b0);
        check("ack err clear", err, 1'b0);
        check("ack in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int           lat, chg;
        logic         bad;

        keytab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keytab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keytab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keytab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keytab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keytab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keytab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keytab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keytab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keytab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keytab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 4'd0,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 6, 4};
        vecs[1] = '{128'h0, 4'd10,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 6, 4};
        vecs[2] = '{128'h0123456789abcdeffedcba9876543210, 4'd11,
                    128'h0123456789abcdeffedcba9876543210, 1'b1, 1, 0};
        vecs[3] = '{{128{1'b1}}, 4'd5,
                    128'h2b2e3907837c6278350d4743ee06ea43, 1'b0, 6, 4};
        vecs[4] = '{128'hcafef00d112233445566778899aabbcc, 4'd15,
                    128'hcafef00d112233445566778899aabbcc, 1'b1, 1, 0};
        vecs[5] = '{128'h0, 4'd1,
                    128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 6, 4};

        alt       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        state_in  = 128'h0;
        round_num = 4'd0;
        key_ready = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset state_out", state_out, 128'h0);
        check("reset err", err, 1'b0);
        check("reset key_num", key_num, 4'd0);
        check("reset key_idx", key_idx, 2'd0);
        reset = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            accept_req(vecs[i].st, vecs[i].rn);
            wait_out(lat, chg);
            check($sformatf("vec%0d state_out", i), state_out, vecs[i].exp);
            check($sformatf("vec%0d err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d key_idx steps", i), chg, vecs[i].exp_chg);
            ack(i % 3, vecs[i].exp, vecs[i].exp_err);
        end

        // key_ready low for 20 cycles with the request parked in WAIT_KEY
        key_ready = 1'b0;
        accept_req(128'h00112233445566778899aabbccddeeff, 4'd2);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || key_idx !== 2'd0)
                bad = 1'b1;
        end
        check("wait_key idle", bad, 1'b0);
        key_ready = 1'b1;
        wait_out(lat, chg);
        check("wait_key state_out", state_out, 128'hf2d3b7c13ec3df34d1ac2ac1bf841880);
        ack(5, 128'hf2d3b7c13ec3df34d1ac2ac1bf841880, 1'b0);

        // Expander restart after word 2: result must use the fresh key only
        accept_req(128'h0, 4'd3);
        lat = 0;
        while (key_idx != 2'd3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("restart reach word3", key_idx, 2'd3);
        key_ready = 1'b0;
        alt       = 1'b1;
        @(posedge clk); #1;
        check("restart key_idx", key_idx, 2'd0);
        check("restart out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        key_ready = 1'b1;
        wait_out(lat, chg);
        check("restart state_out", state_out, 128'h67da1d271d4ca4644479241e3720d261);
        ack(0, 128'h0, 1'b0);
        key_ready = 1'b0;
        alt       = 1'b0;
        @(posedge clk); #1;
        key_ready = 1'b1;

        // Reset while fetching drops the request
        accept_req(128'h0, 4'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset in_ready", in_ready, 1'b0);
        check("midreset key_idx", key_idx, 2'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("after reset in_ready", in_ready, 1'b1);
        check("after reset out_valid", out_valid, 1'b0);
        accept_req(vecs[0].st, 4'd0);
        wait_out(lat, chg);
        check("after reset state_out", state_out, vecs[0].exp);
        ack(0, vecs[0].exp, 1'b0);

`ifdef ADDKEY_CACHE_EN
        accept_req(128'h0, 4'd5);
        wait_out(lat, chg);
        check("cache miss latency", lat, 6);
        check("cache miss state_out", state_out, keytab[5]);
        ack(0, keytab[5], 1'b0);
        accept_req({128{1'b1}}, 4'd5);
        wait_out(lat, chg);
        check("cache hit latency", lat, 2);
        check("cache hit key_idx steps", chg, 0);
        check("cache hit state_out", state_out, 128'h2b2e3907837c6278350d4743ee06ea43);
        ack(0, 128'h2b2e3907837c6278350d4743ee06ea43, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
